motor_supervisor: RTL and testbench
===================================

# motor_supervisor

Drive-safety sequencer between the IPS line-following command logic and the two 12-bit motor PWM generators / H-bridge direction pins of the rover. It soft-starts duty increases, forces a coast dead-band on every direction change, and runs an overcurrent fault FSM: cooldown, limited auto-retry, then latched lockout. The block owns the H-bridge inputs IN1–IN4 and the duty words fed to both PWM instances.

## Interface
- DUTY_W, 12 — duty word width; matches the PWM generators.
- RAMP_STEP, 16 — maximum duty increase per ramp tick.
- RAMP_DIV, 100000 — cycles per ramp tick (1 ms at 100 MHz).
- DEADTIME, 1000000 — coast cycles on a direction change (10 ms).
- OC_FILT, 1000 — consecutive cycles of overcurrent required to trip.
- COOLDOWN, 50000000 — cycles spent in FAULT before a retry (0.5 s).
- MAX_RETRY, 3 — fault entries allowed before lockout.
- CLEAR_TIME, 200000000 — fault-free RUN cycles that clear retry_count (2 s).

- CLK100MHZ  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- req_duty_A, req_duty_B  in  DUTY_W  requested duty per motor.
- req_dir_A, req_dir_B  in  2  requested bridge code {INx,INy}: 10 fwd, 01 rev, 00 coast, 11 brake.
- OCA, OCB  in  1  overcurrent flags, active-low, asynchronous to CLK100MHZ.
- clear_fault  in  1  single-cycle pulse; exits LOCKOUT.
- motor_duty_A, motor_duty_B  out  DUTY_W  duty to the PWM generators.
- IN1, IN2, IN3, IN4  out  1  bridge inputs; {IN1,IN2}=motor A, {IN3,IN4}=motor B.
- fault_active  out  1  high in FAULT or LOCKOUT.
- lockout  out  1  high in LOCKOUT only.
- retry_count  out  2  fault entries since last clear.

## Operation
- Reset: state RUN, all duty outputs 0, IN1–IN4 0, fault_active/lockout 0, retry_count 0, ramps at 0, filter counters 0.
- OCA/OCB each pass through a 2-flop synchronizer; a shared filter counter increments each cycle in which either synchronized flag is low, and clears on any cycle in which both are high; it saturates at OC_FILT.
- Global FSM states: RUN, FAULT, LOCKOUT.
  - RUN: channels operate normally. Filter reaching OC_FILT → FAULT if retry_count < MAX_RETRY (retry_count+1), else → LOCKOUT. A CLEAR_TIME counter runs in RUN, resets on any filter increment, and zeroes retry_count when it expires.
  - FAULT: duties 0, IN 0000, COOLDOWN counter runs; on expiry → RUN with both channels restarted from duty 0. Overcurrent during FAULT is ignored.
  - LOCKOUT: duties 0, IN 0000; clear_fault → RUN, retry_count 0, channels restarted. clear_fault ignored in RUN/FAULT.
- Per-channel (RUN only):
  - Decreases apply immediately: if req < applied, applied = req next cycle.
  - Increases apply on ramp ticks: applied = min(req, applied+RAMP_STEP); no overflow past 2^DUTY_W−1.
  - A req_dir differing from the applied code enters dead-band: applied code 00, duty 0, counter loaded with DEADTIME. Any further req_dir change during dead-band reloads the counter and latches the latest code. On expiry, the latched code is applied and duty ramps from 0.
  - Codes 00 and 11 apply duty as commanded; brake/coast are not treated specially beyond direction-change handling.
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronous) and restarts all counters.

## Timing
- All outputs are registered.
- Duty decrease: visible 1 cycle after req changes.
- Ramp tick: a free-running divider of RAMP_DIV cycles, shared by both channels; from 0 to full-scale 4095 takes ceil(4095/RAMP_STEP) ticks.
- Overcurrent trip: outputs read 0 exactly OC_FILT+2 cycles after the first edge that samples OCA or OCB low, provided it stays low.
- Direction change: IN goes to 00 and duty to 0 one cycle after req_dir changes. The new code appears DEADTIME cycles later.
- FAULT lasts exactly COOLDOWN cycles.

## Structure
- Shared package: bridge code constants (FWD, REV, COAST, BRAKE), FSM state encoding, DUTY_W default.
- One sub-module, motor_channel_ramp, instantiated twice, holds the ramp, dead-band counter and applied direction. It takes tick, restart and enable inputs from the top-level FSM.

## Test plan
Bench parameters: RAMP_DIV=4, RAMP_STEP=16, DEADTIME=8, OC_FILT=3, COOLDOWN=20, MAX_RETRY=3, CLEAR_TIME=50.
- Soft-start: req_duty_A=100, dir 10 → motor_duty_A steps 0,16,…,96,100 on successive ticks; drop req to 20 → 20 next cycle.
- Reversal: dir 10→01 at duty 64 → IN1/IN2=00 and duty 0 next cycle; IN1/IN2=01 after 8 cycles; duty ramps from 0.
- Glitch rejection: OCA low 2 cycles → no fault. OCA low 3+ cycles → duties 0 after 5 cycles, fault_active=1, retry_count=1, RUN again after 20 cycles.
- Lockout: 4 back-to-back faults → lockout=1 with retry_count=3. clear_fault pulse → RUN, retry_count=0, duty ramping from 0.
- Retry clear: fault, then 50 clean RUN cycles → retry_count=0.
- Async reset during FAULT → all outputs 0 and state RUN without waiting for a clock edge.

Source files
------------

// File: rtl/motor_supervisor_pkg.sv
// Shared bridge codes, supervisor state encoding and duty-width default for the motor supervisor.
// Pure declarations: no latency, no flow control.
package motor_supervisor_pkg;

  localparam int DUTY_W_DEF = 12;

  // Bridge codes as {INx,INy}
  localparam logic [1:0] BR_FWD   = 2'b10;
  localparam logic [1:0] BR_REV   = 2'b01;
  localparam logic [1:0] BR_COAST = 2'b00;
  localparam logic [1:0] BR_BRAKE = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FAULT   = 2'd1,
    ST_LOCKOUT = 2'd2
  } sup_state_t;

endpackage

// File: rtl/motor_supervisor_if.sv
// Command, overcurrent-sense and bridge/PWM drive bundle; slave is the supervisor side.
// Plain wires: no latency, no backpressure (continuously sampled control signals).
interface motor_supervisor_if #(
  parameter int DUTY_W = motor_supervisor_pkg::DUTY_W_DEF
);
  logic [DUTY_W-1:0] req_duty_A;
  logic [DUTY_W-1:0] req_duty_B;
  logic [1:0]        req_dir_A;
  logic [1:0]        req_dir_B;
  logic              OCA;
  logic              OCB;
  logic              clear_fault;
  logic [DUTY_W-1:0] motor_duty_A;
  logic [DUTY_W-1:0] motor_duty_B;
  logic              IN1;
  logic              IN2;
  logic              IN3;
  logic              IN4;
  logic              fault_active;
  logic              lockout;
  logic [1:0]        retry_count;

  modport master (
    output req_duty_A, req_duty_B, req_dir_A, req_dir_B, OCA, OCB, clear_fault,
    input  motor_duty_A, motor_duty_B, IN1, IN2, IN3, IN4, fault_active, lockout, retry_count
  );

  modport slave (
    input  req_duty_A, req_duty_B, req_dir_A, req_dir_B, OCA, OCB, clear_fault,
    output motor_duty_A, motor_duty_B, IN1, IN2, IN3, IN4, fault_active, lockout, retry_count
  );

endinterface

// File: rtl/motor_channel_ramp.sv
// One motor channel: soft-start ramp, immediate decreases, coast dead-band on direction change.
// Latency: 1 cycle for decreases/dead-band entry, ramp on ticks; no backpressure.
module motor_channel_ramp
  import motor_supervisor_pkg::*;
#(
  parameter int DUTY_W    = DUTY_W_DEF,
  parameter int RAMP_STEP = 16,
  parameter int DEADTIME  = 1000000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tick,
  input  logic              i_restart,
  input  logic              i_en,
  input  logic [DUTY_W-1:0] i_req_duty,
  input  logic [1:0]        i_req_dir,
  output logic [DUTY_W-1:0] o_duty,
  output logic [1:0]        o_dir
);
  localparam int DB_W = $clog2(DEADTIME + 1);

  logic [DUTY_W-1:0] r_duty;
  logic [1:0]        r_dir;
  logic [1:0]        r_latch;
  logic              r_in_db;
  logic [DB_W-1:0]   r_db_cnt;
  logic [DUTY_W:0]   w_step_sum;
  logic [DUTY_W-1:0] w_ramp;
  logic              w_dir_chg;

  // One extra bit so the step sum cannot wrap past full scale
  always_comb begin
    w_step_sum = {1'b0, r_duty} + (DUTY_W+1)'(RAMP_STEP);
    w_ramp     = (w_step_sum > {1'b0, i_req_duty}) ? i_req_duty : w_step_sum[DUTY_W-1:0];
    w_dir_chg  = r_in_db ? (i_req_dir != r_latch) : (i_req_dir != r_dir);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_duty   <= '0;
      r_dir    <= BR_COAST;
      r_latch  <= BR_COAST;
      r_in_db  <= 1'b0;
      r_db_cnt <= '0;
    end else if (i_restart || !i_en) begin
      r_duty   <= '0;
      r_dir    <= BR_COAST;
      r_latch  <= BR_COAST;
      r_in_db  <= 1'b0;
      r_db_cnt <= '0;
    end else if (w_dir_chg) begin
      r_duty   <= '0;
      r_dir    <= BR_COAST;
      r_latch  <= i_req_dir;
      r_in_db  <= 1'b1;
      r_db_cnt <= DB_W'(DEADTIME);
    end else if (r_in_db) begin
      if (r_db_cnt == DB_W'(1)) begin
        r_in_db <= 1'b0;
        r_dir   <= r_latch;
      end
      r_db_cnt <= r_db_cnt - DB_W'(1);
    end else if (i_req_duty < r_duty) begin
      r_duty <= i_req_duty;
    end else if (i_tick && (i_req_duty > r_duty)) begin
      r_duty <= w_ramp;
    end
  end

  assign o_duty = r_duty;
  assign o_dir  = r_dir;

endmodule

// File: rtl/motor_supervisor.sv
// Drive-safety sequencer: OC filter, RUN/FAULT/LOCKOUT FSM with limited retry, two ramped channels.
// Latency: decrease 1 cycle, trip OC_FILT+2 cycles after first low sample; no backpressure.
module motor_supervisor
  import motor_supervisor_pkg::*;
#(
  parameter int DUTY_W     = DUTY_W_DEF,
  parameter int RAMP_STEP  = 16,
  parameter int RAMP_DIV   = 100000,
  parameter int DEADTIME   = 1000000,
  parameter int OC_FILT    = 1000,
  parameter int COOLDOWN   = 50000000,
  parameter int MAX_RETRY  = 3,
  parameter int CLEAR_TIME = 200000000
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  motor_supervisor_if.slave io_sup
);
  localparam int DIV_W  = $clog2(RAMP_DIV);
  localparam int FILT_W = $clog2(OC_FILT + 1);
  localparam int COOL_W = $clog2(COOLDOWN);
  localparam int CLR_W  = $clog2(CLEAR_TIME);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RAMP_DIV - 1);
  localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(OC_FILT);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN - 1);
  localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CLEAR_TIME - 1);
  localparam logic [1:0]        RETRY_MAX = 2'(MAX_RETRY);

  logic [1:0]        r_oca_sync;
  logic [1:0]        r_ocb_sync;
  logic [FILT_W-1:0] r_filt;
  logic [DIV_W-1:0]  r_div;
  logic [COOL_W-1:0] r_cool;
  logic [CLR_W-1:0]  r_clr;
  sup_state_t        r_state;
  sup_state_t        w_state_nxt;
  logic [1:0]        r_retry;
  logic [1:0]        w_retry_nxt;
  logic              w_oc;
  logic              w_tick;
  logic              w_run;
  logic              w_restart;
  logic [DUTY_W-1:0] w_duty_a;
  logic [DUTY_W-1:0] w_duty_b;
  logic [1:0]        w_dir_a;
  logic [1:0]        w_dir_b;

  assign w_oc   = ~r_oca_sync[1] | ~r_ocb_sync[1];
  assign w_tick = (r_div == DIV_LAST);
  assign w_run  = (r_state == ST_RUN);

  // Synchronizers idle high so reset never looks like an overcurrent
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_oca_sync <= 2'b11;
      r_ocb_sync <= 2'b11;
      r_filt     <= '0;
      r_div      <= '0;
    end else begin
      r_oca_sync <= {r_oca_sync[0], io_sup.OCA};
      r_ocb_sync <= {r_ocb_sync[0], io_sup.OCB};
      r_div      <= w_tick ? '0 : r_div + DIV_W'(1);
      if (!w_oc) begin
        r_filt <= '0;
      end else if (r_filt != FILT_MAX) begin
        r_filt <= r_filt + FILT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_restart   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (r_filt == FILT_MAX) begin
          w_restart = 1'b1;
          if (r_retry < RETRY_MAX) begin
            w_state_nxt = ST_FAULT;
            w_retry_nxt = r_retry + 2'd1;
          end else begin
            w_state_nxt = ST_LOCKOUT;
          end
        end else if ((r_clr == CLR_LAST) && !w_oc) begin
          w_retry_nxt = 2'd0;
        end
      end
      ST_FAULT: begin
        if (r_cool == COOL_LAST) begin
          w_state_nxt = ST_RUN;
          w_restart   = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (io_sup.clear_fault) begin
          w_state_nxt = ST_RUN;
          w_retry_nxt = 2'd0;
          w_restart   = 1'b1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_retry <= 2'd0;
      r_cool  <= '0;
      r_clr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_retry <= w_retry_nxt;
      r_cool  <= ((r_state == ST_FAULT) && (r_cool != COOL_LAST)) ? r_cool + COOL_W'(1) : '0;
      r_clr   <= (!w_run || w_oc || (r_clr == CLR_LAST)) ? '0 : r_clr + CLR_W'(1);
    end
  end

  motor_channel_ramp #(
    .DUTY_W(DUTY_W), .RAMP_STEP(RAMP_STEP), .DEADTIME(DEADTIME)
  ) u_chan_a (
    .i_clk(CLK100MHZ), .i_rst(reset), .i_tick(w_tick), .i_restart(w_restart), .i_en(w_run),
    .i_req_duty(io_sup.req_duty_A), .i_req_dir(io_sup.req_dir_A),
    .o_duty(w_duty_a), .o_dir(w_dir_a)
  );

  motor_channel_ramp #(
    .DUTY_W(DUTY_W), .RAMP_STEP(RAMP_STEP), .DEADTIME(DEADTIME)
  ) u_chan_b (
    .i_clk(CLK100MHZ), .i_rst(reset), .i_tick(w_tick), .i_restart(w_restart), .i_en(w_run),
    .i_req_duty(io_sup.req_duty_B), .i_req_dir(io_sup.req_dir_B),
    .o_duty(w_duty_b), .o_dir(w_dir_b)
  );

  assign io_sup.motor_duty_A = w_duty_a;
  assign io_sup.motor_duty_B = w_duty_b;
  assign io_sup.IN1          = w_dir_a[1];
  assign io_sup.IN2          = w_dir_a[0];
  assign io_sup.IN3          = w_dir_b[1];
  assign io_sup.IN4          = w_dir_b[0];
  assign io_sup.fault_active = !w_run;
  assign io_sup.lockout      = (r_state == ST_LOCKOUT);
  assign io_sup.retry_count  = r_retry;

endmodule

// File: tb/tb_motor_supervisor.sv
// Bench for motor_supervisor: directed scenarios plus random traffic against a reference model.
module tb_motor_supervisor;
  import motor_supervisor_pkg::*;

  localparam int DW         = 12;
  localparam int RAMP_DIV   = 4;
  localparam int RAMP_STEP  = 16;
  localparam int DEADTIME   = 8;
  localparam int OC_FILT    = 3;
  localparam int COOLDOWN   = 20;
  localparam int MAX_RETRY  = 3;
  localparam int CLEAR_TIME = 50;
  localparam int S_RUN = 0, S_FAULT = 1, S_LOCK = 2;
  localparam int FULL = (1 << DW) - 1;

  logic CLK100MHZ = 1'b0;
  logic reset;
  always #5 CLK100MHZ = ~CLK100MHZ;

  motor_supervisor_if #(.DUTY_W(DW)) sif();

  motor_supervisor #(
    .DUTY_W(DW), .RAMP_STEP(RAMP_STEP), .RAMP_DIV(RAMP_DIV), .DEADTIME(DEADTIME),
    .OC_FILT(OC_FILT), .COOLDOWN(COOLDOWN), .MAX_RETRY(MAX_RETRY), .CLEAR_TIME(CLEAR_TIME)
  ) dut (
    .CLK100MHZ(CLK100MHZ),
    .reset(reset),
    .io_sup(sif)
  );

  typedef struct {
    int da; int db; int in_a; int in_b; int fa; int lo; int rc;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: spec rules in plain integers
  int m_cyc, m_filt, m_state, m_retry, m_fault_t, m_clean;
  bit m_oc_d1, m_oc_d2;
  int m_duty[2], m_dir[2], m_db[2], m_pend[2];

  task automatic chk(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_filt = 0; m_state = S_RUN; m_retry = 0; m_fault_t = 0; m_clean = 0;
    m_oc_d1 = 0; m_oc_d2 = 0;
    for (int c = 0; c < 2; c++) begin
      m_duty[c] = 0; m_dir[c] = 0; m_db[c] = 0; m_pend[c] = 0;
    end
  endtask

  task automatic model_step();
    int  rq_duty[2];
    int  rq_dir[2];
    int  cur;
    bit  oc_seen, tick, trip;
    obs_t o;
    rq_duty[0] = int'(sif.req_duty_A); rq_duty[1] = int'(sif.req_duty_B);
    rq_dir[0]  = int'(sif.req_dir_A);  rq_dir[1]  = int'(sif.req_dir_B);
    oc_seen = m_oc_d2;
    m_cyc++;
    tick = (m_cyc % RAMP_DIV) == 0;
    trip = (m_state == S_RUN) && (m_filt == OC_FILT);
    for (int c = 0; c < 2; c++) begin
      cur = (m_db[c] > 0) ? m_pend[c] : m_dir[c];
      if (m_state != S_RUN || trip) begin
        m_duty[c] = 0; m_dir[c] = 0; m_db[c] = 0; m_pend[c] = 0;
      end else if (rq_dir[c] != cur) begin
        m_duty[c] = 0; m_dir[c] = 0; m_pend[c] = rq_dir[c]; m_db[c] = DEADTIME;
      end else if (m_db[c] > 0) begin
        m_db[c]--;
        if (m_db[c] == 0) m_dir[c] = m_pend[c];
      end else if (rq_duty[c] < m_duty[c]) begin
        m_duty[c] = rq_duty[c];
      end else if (tick && rq_duty[c] > m_duty[c]) begin
        m_duty[c] = (m_duty[c] + RAMP_STEP > rq_duty[c]) ? rq_duty[c] : m_duty[c] + RAMP_STEP;
      end
    end
    case (m_state)
      S_RUN: begin
        if (trip) begin
          if (m_retry < MAX_RETRY) begin
            m_state = S_FAULT; m_retry++; m_fault_t = 0;
          end else begin
            m_state = S_LOCK;
          end
          m_clean = 0;
        end else if (oc_seen) begin
          m_clean = 0;
        end else begin
          m_clean++;
          if (m_clean == CLEAR_TIME) begin m_retry = 0; m_clean = 0; end
        end
      end
      S_FAULT: begin
        m_fault_t++;
        if (m_fault_t == COOLDOWN) m_state = S_RUN;
      end
      default: if (sif.clear_fault) begin m_state = S_RUN; m_retry = 0; end
    endcase
    m_filt  = oc_seen ? ((m_filt < OC_FILT) ? m_filt + 1 : m_filt) : 0;
    m_oc_d2 = m_oc_d1;
    m_oc_d1 = !sif.OCA || !sif.OCB;
    o.da = m_duty[0]; o.db = m_duty[1]; o.in_a = m_dir[0]; o.in_b = m_dir[1];
    o.fa = (m_state != S_RUN) ? 1 : 0;
    o.lo = (m_state == S_LOCK) ? 1 : 0;
    o.rc = m_retry;
    exp_q.push_back(o);
  endtask

  // Inputs change at negedge; the model predicts the state after the next posedge
  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(negedge CLK100MHZ);
    end
  endtask

  always @(posedge CLK100MHZ) begin : monitor
    obs_t e;
    #1;
    if (!reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("duty_A", int'(sif.motor_duty_A), e.da);
      chk("duty_B", int'(sif.motor_duty_B), e.db);
      chk("IN12", int'({sif.IN1, sif.IN2}), e.in_a);
      chk("IN34", int'({sif.IN3, sif.IN4}), e.in_b);
      chk("fault_active", int'(sif.fault_active), e.fa);
      chk("lockout", int'(sif.lockout), e.lo);
      chk("retry_count", int'(sif.retry_count), e.rc);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_duty_A"}, int'(sif.motor_duty_A), 0);
    chk({tag, "_duty_B"}, int'(sif.motor_duty_B), 0);
    chk({tag, "_IN"}, int'({sif.IN1, sif.IN2, sif.IN3, sif.IN4}), 0);
    chk({tag, "_fault_active"}, int'(sif.fault_active), 0);
    chk({tag, "_lockout"}, int'(sif.lockout), 0);
    chk({tag, "_retry"}, int'(sif.retry_count), 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int oc_left;
    int oc_sel;
    reset = 1'b1;
    sif.req_duty_A = '0; sif.req_duty_B = '0;
    sif.req_dir_A = BR_COAST; sif.req_dir_B = BR_COAST;
    sif.OCA = 1'b1; sif.OCB = 1'b1; sif.clear_fault = 1'b0;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge CLK100MHZ);
    reset = 1'b0;

    // Soft-start A 0..100 forward, B 0..50 reverse
    sif.req_dir_A = BR_FWD; sif.req_duty_A = 12'd100;
    sif.req_dir_B = BR_REV; sif.req_duty_B = 12'd50;
    cycle(60);
    chk("softstart_A", int'(sif.motor_duty_A), 100);
    chk("softstart_B", int'(sif.motor_duty_B), 50);
    sif.req_duty_A = 12'd20;
    cycle(1);
    chk("decrease_A", int'(sif.motor_duty_A), 20);

    // Reversal at duty 64
    sif.req_duty_A = 12'd64;
    cycle(30);
    chk("pre_rev_A", int'(sif.motor_duty_A), 64);
    sif.req_dir_A = BR_REV;
    cycle(1);
    chk("rev_coast_IN", int'({sif.IN1, sif.IN2}), 0);
    chk("rev_coast_duty", int'(sif.motor_duty_A), 0);
    cycle(DEADTIME - 1);
    chk("rev_still_coast", int'({sif.IN1, sif.IN2}), 0);
    cycle(1);
    chk("rev_applied", int'({sif.IN1, sif.IN2}), int'(BR_REV));

    // Full-scale ramp must stop at 4095 without wrapping
    sif.req_duty_A = 12'(FULL);
    cycle(1100);
    chk("fullscale_A", int'(sif.motor_duty_A), FULL);

    // Glitch rejection then a real trip
    sif.OCA = 1'b0; cycle(2); sif.OCA = 1'b1;
    cycle(10);
    chk("glitch_no_fault", int'(sif.fault_active), 0);
    sif.OCA = 1'b0; cycle(3); sif.OCA = 1'b1;
    cycle(3);
    chk("trip_fault_active", int'(sif.fault_active), 1);
    chk("trip_retry", int'(sif.retry_count), 1);
    chk("trip_duty_A", int'(sif.motor_duty_A), 0);
    cycle(COOLDOWN);
    chk("cooldown_done", int'(sif.fault_active), 0);
    cycle(60);
    chk("retry_cleared", int'(sif.retry_count), 0);

    // Persistent overcurrent: three retries then lockout
    sif.OCA = 1'b0;
    cycle(120);
    chk("lockout_set", int'(sif.lockout), 1);
    chk("lockout_retry", int'(sif.retry_count), 3);
    sif.OCA = 1'b1;
    cycle(5);
    sif.clear_fault = 1'b1; cycle(1); sif.clear_fault = 1'b0;
    chk("clear_lockout", int'(sif.lockout), 0);
    chk("clear_retry", int'(sif.retry_count), 0);
    cycle(40);

    // Asynchronous reset while in FAULT
    sif.OCB = 1'b0; cycle(4); sif.OCB = 1'b1;
    cycle(4);
    chk("pre_reset_fault", int'(sif.fault_active), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge CLK100MHZ);
    reset = 1'b0;

    // Random traffic
    oc_left = 0;
    oc_sel  = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0)
        sif.req_duty_A = $urandom_range(0, 1) ? 12'(FULL - $urandom_range(0, 20)) : 12'($urandom_range(0, FULL));
      if ($urandom_range(0, 15) == 0)
        sif.req_duty_B = 12'($urandom_range(0, FULL));
      if ($urandom_range(0, 39) == 0) sif.req_dir_A = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) sif.req_dir_B = 2'($urandom_range(0, 3));
      if (oc_left > 0) begin
        oc_left--;
      end else if ($urandom_range(0, 59) == 0) begin
        oc_left = $urandom_range(1, 6);
        oc_sel  = $urandom_range(0, 1);
      end
      sif.OCA = !(oc_left > 0 && oc_sel == 0);
      sif.OCB = !(oc_left > 0 && oc_sel == 1);
      sif.clear_fault = ($urandom_range(0, 29) == 0);
      cycle(1);
    end
    sif.clear_fault = 1'b0;
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
